montgomery_mult_param: RTL
==========================

// Module: montgomery_mult_param
// PURPOSE
//   Parametrised iterative Montgomery modular multiplier: result = A*B*2^-WIDTH mod M.
//   Successor of the fixed 1024-bit start/done multiplier. Adds generic operand width,
//   STEPS radix-2 iterations unrolled per cycle, a busy flag and operand latching at start.
//   Core arithmetic primitive for the modular-exponentiation (RSA) datapath.
// PARAMETERS
//   WIDTH  1024  operand/modulus width in bits; R = 2^WIDTH
//   STEPS  1     radix-2 iterations per clock; WIDTH % STEPS == 0 (elaboration error otherwise)
// PORTS
//   clk     in   1      rising-edge clock, single clock domain
//   resetn  in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only while idle (busy==0)
//   in_a    in   WIDTH  multiplicand A, 0 <= A < M
//   in_b    in   WIDTH  multiplier B, 0 <= B < M
//   in_m    in   WIDTH  modulus M, odd, M < 2^WIDTH
//   result  out  WIDTH  Montgomery product, held stable until next accepted start
//   busy    out  1      high from the cycle after start is accepted until done
//   done    out  1      single-cycle pulse: result valid
// BEHAVIOUR
//   Reset (async assert, sync deassert at clk edge): state=IDLE, result=0, busy=0, done=0,
//     all internal registers=0. Reset mid-operation aborts it; no done pulse is produced.
//   FSM: IDLE -> LOOP -> [SUB] -> DONE -> IDLE.
//     IDLE: on start=1, latch A, B, M; C=0; i=0; busy<=1; go to LOOP.
//     LOOP: per cycle, apply STEPS iterations, LSB-first over A:
//       C = C + a_i*B; if C[0] then C = C + M; C = C >> 1; i = i+1.
//       C register is WIDTH+2 bits; no intermediate overflow is permitted.
//       After WIDTH/STEPS cycles (i == WIDTH), C < 2M; go to SUB (macro on) or DONE.
//     SUB: if C >= M then C = C - M (single WIDTH+2-bit compare/subtract); go to DONE.
//     DONE: result <= C[WIDTH-1:0]; done=1 for this cycle only; busy<=0; go to IDLE.
//   Latency: start sampled at edge k -> done high in cycle k + WIDTH/STEPS + 2 (macro on)
//     or k + WIDTH/STEPS + 1 (macro off). Back-to-back: start is accepted again the cycle
//     after done (done and busy are never both high).
//   start while busy: ignored; no queueing, no effect on the running operation.
//   in_a/in_b/in_m may change after the start cycle; only latched values are used.
//   A or B >= M, or even M: result undefined, but the FSM still completes with the nominal latency.
//   A=0 or B=0 -> result 0.
// CONFIGURATION
//   MONT_FINAL_SUB_EN defined: SUB state present; result fully reduced, 0 <= result < M.
//   MONT_FINAL_SUB_EN undefined: SUB state removed, one cycle shorter; result is congruent to the
//     true product mod M with 0 <= result < 2M (for chained exponentiation with 2M < 2^WIDTH);
//     result = C[WIDTH-1:0]; a set bit at C[WIDTH] or C[WIDTH+1] is a precondition violation.
// TESTING
//   T1 WIDTH=8,STEPS=1,M=0xC5: A=0x01,B=0x3B (R mod M) -> result 0x01; done at start+10 (macro on).
//   T2 WIDTH=8,M=0xC5: A=0xC4,B=0xC4 -> result 0xBB (R^-1 mod M); repeat with STEPS=2,4,8 ->
//      same result, latency WIDTH/STEPS+2.
//   T3 WIDTH=8: A=0x00,B=0x7F,M=0xC5 -> result 0x00; busy high only between start and done.
//   T4 WIDTH=1024,STEPS=1 and 4: generator-script golden vector -> result equals the script's
//      expected value; macro off: result mod M equals expected and result < 2M.
//   T5 Pulse start again mid-LOOP and change in_a -> ignored, T1 result unchanged; then drop
//      resetn mid-LOOP -> busy=0, done=0, result=0 immediately, no done pulse; next start
//      computes correctly.
//   T6 Random regression, 1000 ops, WIDTH=64, STEPS in {1,2,8}, random odd M, A,B < M,
//      start issued the cycle after each done -> all match the reference model.

Source files
------------

// File: rtl/montgomery_mult_param.sv
// Iterative radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M, STEPS bits of A per clock.
// Build option MONT_FINAL_SUB_EN: when defined, a final conditional subtraction gives 0 <= result < M.
// When it is undefined, that stage is removed, done comes one cycle earlier and 0 <= result < 2M.
module montgomery_mult_param #(
   parameter int unsigned WIDTH = 1024,
   parameter int unsigned STEPS = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   // Two guard bits: C < 2M on entry, and C + B + M < 4M < 2^(WIDTH+2).
   localparam int unsigned CW       = WIDTH + 2;
   localparam int unsigned STEPS_NZ = (STEPS == 0) ? 1 : STEPS;
   localparam int unsigned CYCLES   = WIDTH / STEPS_NZ;
   localparam int unsigned CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   generate
      if (STEPS == 0 || (WIDTH % STEPS_NZ) != 0) begin : g_bad_steps
         $error("montgomery_mult_param: WIDTH must be a non-zero multiple of STEPS");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOOP = 2'd1,
      ST_SUB  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t             state_q, state_nxt;
   logic [WIDTH-1:0]   a_q, b_q, m_q;
   logic [CW-1:0]      c_q, c_step;
   logic [CNT_W-1:0]   cnt_q;
   logic               last_cycle;
   logic               load, step_en, finish;
`ifdef MONT_FINAL_SUB_EN
   logic               sub_en;
   logic [CW-1:0]      c_sub;
`endif

   assign last_cycle = (cnt_q == CNT_W'(CYCLES - 1));

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_nxt = ST_LOOP;
`ifdef MONT_FINAL_SUB_EN
         ST_LOOP: if (last_cycle) state_nxt = ST_SUB;
         ST_SUB:  state_nxt = ST_DONE;
`else
         ST_LOOP: if (last_cycle) state_nxt = ST_DONE;
`endif
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath control decoded from the current state
   always_comb begin
      load    = 1'b0;
      step_en = 1'b0;
      finish  = 1'b0;
`ifdef MONT_FINAL_SUB_EN
      sub_en  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: load    = start;
         ST_LOOP: step_en = 1'b1;
`ifdef MONT_FINAL_SUB_EN
         ST_SUB:  sub_en  = 1'b1;
`endif
         ST_DONE: finish  = 1'b1;
         default: ;
      endcase
   end

   // STEPS unrolled radix-2 iterations, consuming A from its LSB
   always_comb begin
      c_step = c_q;
      for (int s = 0; s < int'(STEPS_NZ); s++) begin
         if (a_q[s])    c_step = c_step + CW'(b_q);
         if (c_step[0]) c_step = c_step + CW'(m_q);
         c_step = c_step >> 1;
      end
   end

`ifdef MONT_FINAL_SUB_EN
   // Final conditional subtraction bringing C from [0,2M) into [0,M)
   always_comb begin
      c_sub = c_q;
      if (c_q >= CW'(m_q)) c_sub = c_q - CW'(m_q);
   end
`endif

   // Operand latches, accumulator, iteration counter and registered outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         c_q    <= '0;
         cnt_q  <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            c_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
         end
         if (step_en) begin
            c_q   <= c_step;
            a_q   <= a_q >> STEPS_NZ;
            cnt_q <= cnt_q + CNT_W'(1);
         end
`ifdef MONT_FINAL_SUB_EN
         if (sub_en) c_q <= c_sub;
`endif
         if (finish) begin
            result <= c_q[WIDTH-1:0];
            busy   <= 1'b0;
         end
      end
   end

endmodule
